// File: rtl/fast_clk_ctrl.sv
`timescale 1ns/1ps
// fast_clk_ctrl
// Qualifies an external fast clock by counting its rising edges over fixed
// windows of clk, and sequences glitch-free switchover of the fast clock mux
// between the external source and the internal divided clock.
//
// Ports
//   clk              system clock, the only clock of this block
//   rst_n            asynchronous active-low reset
//   fast_clk_ext_raw external clock, sampled as asynchronous data
//   mode[1:0]        00/11 auto (follow ext_ok), 01 force divided, 10 force ext
//   fast_clk_sel     mux select, 1 = external, 0 = divided
//   fast_clk_en      downstream gate enable, high only while settled in RUN
//   ext_ok           external clock qualified
//   switching        high whenever the sequencer is not in RUN
//   switch_evt       one-cycle pulse in the cycle fast_clk_sel takes a new value
//   edge_cnt_last    edge count of the most recently completed window
//
// state  | meaning
// RUN    | settled, fast clock enabled, watching for a target mismatch
// GATE   | fast clock gated off, letting the downstream clock drain
// SWAP   | one cycle: select reloaded from the current target
// UNGATE | gated, waiting for the mux output to settle (also the reset state)
module fast_clk_ctrl #(
  parameter int WIN_LEN      = 1024,
  parameter int EDGE_MIN     = 128,
  parameter int EDGE_MAX     = 141,
  parameter int GOOD_WINDOWS = 4,
  parameter int LOSS_TIMEOUT = 32,
  parameter int GAP          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fast_clk_ext_raw,
  input  logic [1:0] mode,
  output logic       fast_clk_sel,
  output logic       fast_clk_en,
  output logic       ext_ok,
  output logic       switching,
  output logic       switch_evt,
  output logic [7:0] edge_cnt_last
);

  localparam int WIN_W  = $clog2(WIN_LEN);
  localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);
  localparam int GAP_W  = $clog2(GAP + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(WIN_LEN - 1);
  localparam logic [7:0]        EDGE_LO     = 8'(EDGE_MIN);
  localparam logic [7:0]        EDGE_HI     = 8'(EDGE_MAX);
  localparam logic [GOOD_W-1:0] GOOD_FULL   = GOOD_W'(GOOD_WINDOWS);
  localparam logic [LOSS_W-1:0] LOSS_RELOAD = LOSS_W'(LOSS_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GATE_LAST   = GAP_W'(GAP - 2);
  localparam logic [GAP_W-1:0]  UNGATE_LAST = GAP_W'(GAP - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    GATE   = 2'd1,
    SWAP   = 2'd2,
    UNGATE = 2'd3
  } state_t;

  logic              sync_1, sync_2, sync_hist;
  logic              ext_rise;
  logic [WIN_W-1:0]  win_cnt;
  logic              win_term;
  logic [7:0]        edge_cnt;
  logic [7:0]        edge_fin;
  logic              win_good;
  logic [LOSS_W-1:0] loss_tmr;
  logic              loss;
  logic [GOOD_W-1:0] good_cnt;
  logic              target;
  state_t            state;
  logic [GAP_W-1:0]  gap_cnt;

  // ---------------- external clock sampling ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_hist <= 1'b0;
    end else begin
      sync_1    <= fast_clk_ext_raw;
      sync_2    <= sync_1;
      sync_hist <= sync_2;
    end
  end

  assign ext_rise = sync_2 & ~sync_hist;

  // ---------------- window measurement ----------------
  assign win_term = (win_cnt == WIN_LAST);
  // Count including an edge seen in this cycle, saturating at 255.
  assign edge_fin = (ext_rise && edge_cnt != 8'hFF) ? edge_cnt + 8'd1 : edge_cnt;
  assign win_good = (edge_fin >= EDGE_LO) && (edge_fin <= EDGE_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt       <= '0;
      edge_cnt      <= '0;
      edge_cnt_last <= '0;
    end else begin
      if (win_term) begin
        win_cnt       <= '0;
        edge_cnt      <= '0;
        edge_cnt_last <= edge_fin;
      end else begin
        win_cnt  <= win_cnt + 1'b1;
        edge_cnt <= edge_fin;
      end
    end
  end

  // Loss timer reloads on every edge; reaching zero with no edge in the
  // current cycle means LOSS_TIMEOUT edge-free cycles in a row. It resets to
  // zero, so the source counts as lost until its first edge arrives.
  assign loss = (loss_tmr == '0) && !ext_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_tmr <= '0;
    end else if (ext_rise) begin
      loss_tmr <= LOSS_RELOAD;
    end else if (loss_tmr != '0) begin
      loss_tmr <= loss_tmr - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= '0;
      ext_ok   <= 1'b0;
    end else if (loss || (win_term && !win_good)) begin
      good_cnt <= '0;
      ext_ok   <= 1'b0;
    end else begin
      if (win_term && good_cnt != GOOD_FULL) begin
        good_cnt <= good_cnt + 1'b1;
      end
      ext_ok <= (good_cnt == GOOD_FULL);
    end
  end

  // ---------------- switchover sequencer ----------------
  always_comb begin
    target = ext_ok;
    case (mode)
      2'b01:   target = 1'b0;
      2'b10:   target = 1'b1;
      default: target = ext_ok;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= UNGATE;
      gap_cnt      <= '0;
      fast_clk_sel <= 1'b0;
      fast_clk_en  <= 1'b0;
      switching    <= 1'b1;
      switch_evt   <= 1'b0;
    end else begin
      switch_evt <= 1'b0;
      case (state)
        RUN: begin
          if (target != fast_clk_sel) begin
            state       <= GATE;
            gap_cnt     <= '0;
            fast_clk_en <= 1'b0;
            switching   <= 1'b1;
          end
        end
        GATE: begin
          // GATE holds GAP-1 cycles; with the SWAP cycle that is GAP cycles
          // of gating before the select moves.
          if (gap_cnt == GATE_LAST) begin
            state <= SWAP;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        SWAP: begin
          // Target may have moved back during GATE; then nothing changes.
          fast_clk_sel <= target;
          switch_evt   <= (target != fast_clk_sel);
          state        <= UNGATE;
          gap_cnt      <= '0;
        end
        UNGATE: begin
          if (gap_cnt == UNGATE_LAST) begin
            state       <= RUN;
            fast_clk_en <= 1'b1;
            switching   <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= UNGATE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fast_clk_ctrl.sv
`timescale 1ns/1ps
module tb_fast_clk_ctrl;

  localparam int GAP = 8;

  logic       clk;
  logic       rst_n;
  logic       fast_clk_ext_raw;
  logic [1:0] mode;
  logic       fast_clk_sel;
  logic       fast_clk_en;
  logic       ext_ok;
  logic       switching;
  logic       switch_evt;
  logic [7:0] edge_cnt_last;

  int n_cmp = 0;
  int n_bad = 0;

  logic    ext_run = 1'b0;
  realtime ext_half = 76.294;

  fast_clk_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fast_clk_ext_raw (fast_clk_ext_raw),
    .mode             (mode),
    .fast_clk_sel     (fast_clk_sel),
    .fast_clk_en      (fast_clk_en),
    .ext_ok           (ext_ok),
    .switching        (switching),
    .switch_evt       (switch_evt),
    .edge_cnt_last    (edge_cnt_last)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial fast_clk_ext_raw = 1'b0;
  always begin
    if (ext_run) begin
      fast_clk_ext_raw = 1'b1;
      #(ext_half);
      fast_clk_ext_raw = 1'b0;
      #(ext_half);
    end else begin
      fast_clk_ext_raw = 1'b0;
      #7;
    end
  end

  typedef struct {
    logic [1:0] mode;
    logic       sel_if_ok;
    logic       sel_if_bad;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_range(input string nm, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, " sel"}, int'(fast_clk_sel), 0);
    check({nm, " en"}, int'(fast_clk_en), 0);
    check({nm, " ok"}, int'(ext_ok), 0);
    check({nm, " switching"}, int'(switching), 1);
    check({nm, " evt"}, int'(switch_evt), 0);
    check({nm, " cnt_last"}, int'(edge_cnt_last), 0);
  endtask

  // Wait for the gate-off edge E0 (bounded), then check the 8/8 timing.
  // flip_at > 0 changes mode to flip_mode right after edge E0+flip_at.
  task automatic watch_switch(input string nm, input logic exp_sel, input logic exp_evt,
                              input int budget, input int flip_at, input logic [1:0] flip_mode);
    bit   found = 0;
    logic old_sel, prev_sel, prev_en;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!fast_clk_en) begin found = 1; break; end
    end
    check({nm, " E0 seen"}, int'(found), 1);
    if (found) begin
      check({nm, " switching at E0"}, int'(switching), 1);
      old_sel  = fast_clk_sel;
      prev_sel = fast_clk_sel;
      prev_en  = fast_clk_en;
      for (int k = 1; k <= 2 * GAP + 1; k++) begin
        @(posedge clk); #1;
        if (k == flip_at) mode = flip_mode;
        check({nm, " sel/en same-cycle"},
              int'((fast_clk_sel != prev_sel) && (fast_clk_en != prev_en)), 0);
        prev_sel = fast_clk_sel;
        prev_en  = fast_clk_en;
        if (k == GAP - 1) check({nm, " sel before swap"}, int'(fast_clk_sel), int'(old_sel));
        if (k == GAP) begin
          check({nm, " sel at E0+GAP"}, int'(fast_clk_sel), int'(exp_sel));
          check({nm, " evt at E0+GAP"}, int'(switch_evt), int'(exp_evt));
        end
        if (k == GAP + 1) check({nm, " evt after"}, int'(switch_evt), 0);
        if (k == 2 * GAP - 1) check({nm, " en at E0+2GAP-1"}, int'(fast_clk_en), 0);
        if (k == 2 * GAP) begin
          check({nm, " en at E0+2GAP"}, int'(fast_clk_en), 1);
          check({nm, " switching done"}, int'(switching), 0);
        end
      end
    end
  endtask

  task automatic run_table(input string nm, input bit ok_col);
    for (int i = 0; i < 6; i++) begin
      mode = tbl[i].mode;
      repeat (2 * GAP + 4) @(posedge clk);
      #1;
      check($sformatf("%s[%0d] sel", nm, i), int'(fast_clk_sel),
            int'(ok_col ? tbl[i].sel_if_ok : tbl[i].sel_if_bad));
      check($sformatf("%s[%0d] en", nm, i), int'(fast_clk_en), 1);
      check($sformatf("%s[%0d] ok", nm, i), int'(ext_ok), int'(ok_col));
    end
  endtask

  task automatic release_and_count(input string nm);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= GAP; k++) begin
      @(posedge clk); #1;
      if (k == GAP - 1) check({nm, " en before GAP"}, int'(fast_clk_en), 0);
      if (k == GAP) begin
        check({nm, " en at GAP"}, int'(fast_clk_en), 1);
        check({nm, " switching at GAP"}, int'(switching), 0);
      end
    end
  endtask

  initial begin
    bit dropped;
    int en_low;

    tbl[0] = '{2'b01, 1'b0, 1'b0};
    tbl[1] = '{2'b10, 1'b1, 1'b1};
    tbl[2] = '{2'b11, 1'b1, 1'b0};
    tbl[3] = '{2'b01, 1'b0, 1'b0};
    tbl[4] = '{2'b10, 1'b1, 1'b1};
    tbl[5] = '{2'b00, 1'b1, 1'b0};

    // Reset, forced divided, no external clock.
    rst_n = 1'b0;
    mode  = 2'b01;
    #35;
    check_reset_vals("reset");
    release_and_count("release");
    check("release sel", int'(fast_clk_sel), 0);
    check("release ok", int'(ext_ok), 0);
    repeat (50) @(posedge clk);
    #1;
    check("idle ok", int'(ext_ok), 0);

    // Auto mode with a nominal 6.5536 MHz source: qualify and switch to ext.
    mode     = 2'b00;
    ext_half = 76.294;
    ext_run  = 1'b1;
    repeat (2200) @(posedge clk);
    #1;
    check_range("nominal cnt_last", int'(edge_cnt_last), 134, 135);
    watch_switch("to ext", 1'b1, 1'b1, 6000, 0, 2'b00);
    check("ok after qualify", int'(ext_ok), 1);

    run_table("tbl_ok", 1'b1);

    // Source stops while selected in auto mode.
    ext_run = 1'b0;
    dropped = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (!ext_ok) begin dropped = 1; break; end
    end
    check("loss detected", int'(dropped), 1);
    watch_switch("back to div", 1'b0, 1'b1, 10, 0, 2'b00);

    // 10 MHz source: too many edges, never qualifies.
    ext_half = 49.7;
    ext_run  = 1'b1;
    repeat (3 * 1024 + 100) @(posedge clk);
    #1;
    check_range("fast cnt_last", int'(edge_cnt_last), 203, 207);
    check("fast ok", int'(ext_ok), 0);
    check("fast sel", int'(fast_clk_sel), 0);

    run_table("tbl_bad", 1'b0);

    mode = 2'b10;
    watch_switch("force ext", 1'b1, 1'b1, 10, 0, 2'b00);
    check("force ext ok", int'(ext_ok), 0);

    // Target reverts during GATE: sequence completes without a select change.
    mode = 2'b01;
    watch_switch("force div", 1'b0, 1'b1, 10, 0, 2'b00);
    mode = 2'b10;
    watch_switch("abort", 1'b0, 1'b0, 10, 3, 2'b01);
    en_low = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!fast_clk_en || switching) en_low++;
    end
    check("no new sequence", en_low, 0);

    // Reset asserted mid-switch at E0+3.
    mode = 2'b10;
    begin
      bit found = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (!fast_clk_en) begin found = 1; break; end
      end
      check("midreset E0 seen", int'(found), 1);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("midreset held");
    release_and_count("rerelease");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fast_clk_ctrl.md
FAST_CLK_CTRL -- requirements
Module: fast_clk_ctrl

Interface
REQ-001 Parameter WIN_LEN, default 1024: measurement window length in clk cycles.
REQ-002 Parameter EDGE_MIN, default 128: minimum ext rising edges per window for a good window.
REQ-003 Parameter EDGE_MAX, default 141: maximum ext rising edges per window for a good window.
REQ-004 Parameter GOOD_WINDOWS, default 4: consecutive good windows needed to set ext_ok.
REQ-005 Parameter LOSS_TIMEOUT, default 32: clk cycles without an ext edge that declare loss.
REQ-006 Parameter GAP, default 8: clk cycles for each gate-off and gate-on phase of a switchover.
REQ-007 clk  input  1  50 MHz system clock; the block's only clock.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 fast_clk_ext_raw  input  1  external 6.5536 MHz clock, asynchronous to clk, sampled as data.
REQ-010 mode  input  2  00/11 auto, 01 force divided, 10 force external.
REQ-011 fast_clk_sel  output  1  mux select: 1 ext, 0 divided.
REQ-012 fast_clk_en  output  1  downstream gate enable for the muxed fast clock.
REQ-013 ext_ok  output  1  external clock qualified.
REQ-014 switching  output  1  high whenever the FSM is not in RUN.
REQ-015 switch_evt  output  1  one-cycle pulse in the cycle fast_clk_sel changes value.
REQ-016 edge_cnt_last  output  8  edge count of the most recently completed window.

Function
REQ-017 fast_clk_ext_raw SHALL pass a 2-flop synchronizer plus 1 history flop; a rising edge is sync=1, history=0.
REQ-018 Window counter SHALL count 0..WIN_LEN-1 and wrap; edge counter SHALL saturate at 255.
REQ-019 An edge in the terminal window cycle SHALL count toward the ending window; the edge counter SHALL restart at 0 the next cycle.
REQ-020 At window end, edge_cnt_last SHALL load the final count; the window is good iff EDGE_MIN <= count <= EDGE_MAX.
REQ-021 Good window: good counter increments, saturating at GOOD_WINDOWS; bad window: good counter and ext_ok clear.
REQ-022 ext_ok SHALL be 1 in the cycle after the good counter reaches GOOD_WINDOWS, otherwise 0.
REQ-023 LOSS_TIMEOUT consecutive cycles with no edge SHALL clear ext_ok and the good counter, independent of window position.
REQ-024 Target select: mode 01 -> 0; mode 10 -> 1, regardless of ext_ok; mode 00/11 -> ext_ok.
REQ-025 FSM states: RUN, GATE, SWAP, UNGATE; fast_clk_en=1 only in RUN.
REQ-026 RUN: when target != fast_clk_sel at clock edge E0, go to GATE; fast_clk_en=0 from E0.
REQ-027 GATE SHALL last GAP cycles, then SWAP loads fast_clk_sel from target sampled at that cycle; new value visible from E0+GAP.
REQ-028 If the SWAP-cycle target equals the current select, fast_clk_sel and switch_evt SHALL remain unchanged and the sequence SHALL still complete.
REQ-029 UNGATE SHALL last GAP cycles, then return to RUN; fast_clk_en=1 from E0+2*GAP.
REQ-030 Target changes during GATE/UNGATE SHALL not abort the sequence; a remaining mismatch in RUN starts a new sequence.
REQ-031 fast_clk_sel and fast_clk_en SHALL never change in the same cycle.

Reset
REQ-032 While rst_n=0: fast_clk_sel=0, fast_clk_en=0, ext_ok=0, switching=1, switch_evt=0, edge_cnt_last=0; all counters and sync flops 0; FSM in UNGATE.
REQ-033 After release, UNGATE SHALL run GAP cycles; fast_clk_en=1 from the GAP-th rising edge.
REQ-034 Assertion mid-sequence SHALL force reset values immediately, without waiting for clk.

Verification
REQ-035 Release reset, mode=01, ext idle -> fast_clk_en=1 at edge 8, fast_clk_sel=0, ext_ok=0 throughout.
REQ-036 mode=00, ext 6.5536 MHz -> edge_cnt_last in 134..135; ext_ok=1 after the 4th window; en=0 at E0, sel=1 at E0+8, switch_evt pulse, en=1 at E0+16.
REQ-037 Ext stops while sel=1 in auto -> ext_ok=0 within 32+3 cycles of the last edge; switchover back to sel=0 with 8/8 timing.
REQ-038 Ext 10 MHz (about 204 edges per window), mode=00 -> ext_ok stays 0, sel stays 0; mode=10 -> sel=1 anyway.
REQ-039 mode 01->10, then back to 01 during GATE -> SWAP leaves sel=0, no switch_evt, en=1 at E0+16, no new sequence.
REQ-040 rst_n low at E0+3 of a switch -> all outputs at reset values immediately; en=1 8 edges after release.
